updown_sweep_ctrl: RTL and testbench
====================================

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1: cycles per count step (1..255); cnt_en may assert at most once per TICK_DIV cycles.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  in  1  design enable; low freezes the controller (HOLD behaviour, REQ-015).
REQ-005 SHALL have port cmd_valid  in  1  command strobe.
REQ-006 SHALL have port cmd_op  in  2  00 SET_LO, 01 SET_HI, 10 START, 11 reserved (accepted, no effect).
REQ-007 SHALL have port cmd_data  in  8  bound value for SET_*; for START bit0 = initial direction (1 up), bit1 = bounce mode.
REQ-008 SHALL have port cmd_ready  out  1  high when a command is accepted; transfer happens when cmd_valid && cmd_ready.
REQ-009 SHALL have port abort  in  1  level; ends any sweep.
REQ-010 SHALL have port cnt_q  in  8  current value of the external 8-bit up/down counter.
REQ-011 SHALL have ports cnt_load out 1, cnt_load_val out 8, cnt_en out 1, cnt_up out 1  drive the external counter (load has priority over en in the counter).
REQ-012 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1 (one-cycle pulse), sweeps out 8.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, DONE; busy = (LOAD or RUN).
REQ-014 cmd_ready SHALL equal !busy; SET_LO/SET_HI update the lo/hi registers the cycle after the transfer.
REQ-015 With ena low, state, registers and prescaler SHALL hold, and cnt_load, cnt_en, done, err SHALL be 0.
REQ-016 START with lo > hi SHALL be rejected: err pulses the next cycle, state stays unchanged.
REQ-017 Valid START SHALL enter LOAD: cnt_load=1 for one cycle with cnt_load_val = lo if direction up else hi; target = hi if up else lo.
REQ-018 LOAD SHALL go to RUN unconditionally after one cycle; prescaler reset to 0 on entry to RUN.
REQ-019 In RUN, cnt_up SHALL equal the current direction and cnt_en = tick && (cnt_q != target), combinational on cnt_q; tick asserts when the prescaler equals TICK_DIV-1, then prescaler wraps to 0.
REQ-020 In RUN when cnt_q == target: non-bounce SHALL go to DONE; bounce SHALL invert direction, swap target to the opposite bound and increment sweeps; the counter SHALL never be stepped beyond [lo,hi].
REQ-021 lo == hi SHALL complete immediately after LOAD (non-bounce: DONE; bounce: runs with no steps until abort).
REQ-022 DONE SHALL pulse done for one cycle and return to IDLE next cycle.
REQ-023 abort high in LOAD or RUN SHALL force IDLE next cycle with cnt_en and cnt_load 0 from that cycle on; no done pulse; abort in IDLE/DONE has no effect other than suppressing START.
REQ-024 A START transfer with abort high in the same cycle SHALL be ignored.
REQ-025 cnt_load_val SHALL be 0 when cnt_load is 0.

Reset
REQ-026 Reset SHALL put state IDLE, lo=0x00, hi=0xFF, direction up, prescaler 0, sweeps 0.
REQ-027 During reset all outputs SHALL be 0 except cmd_ready=1 and cnt_up=1; reset mid-sweep takes effect immediately (asynchronous).

Configuration
REQ-028 Macro SWEEP_COUNTER_EN defined: sweeps SHALL count bounce reversals since the last START, saturating at 0xFF, cleared on valid START.
REQ-029 Macro SWEEP_COUNTER_EN undefined: sweeps SHALL be constant 0 and no counter register SHALL be synthesised; all other behaviour identical.

Verification
REQ-030 Reset, SET_LO 0x10, SET_HI 0x14, START up non-bounce, TICK_DIV=1 -> load 0x10, four cnt_en pulses, cnt_q reaches 0x14, done pulses once, busy low, cnt_q stays 0x14.
REQ-031 SET_LO 0x20, SET_HI 0x10, START -> err pulse, busy stays 0, no cnt_load.
REQ-032 lo 0x05, hi 0x07, START down bounce, SWEEP_COUNTER_EN defined -> sequence 07,06,05,06,07,06; sweeps 1 then 2; abort -> IDLE next cycle, no done, sweeps holds 2.
REQ-033 TICK_DIV=4, lo 0x00, hi 0x02 up -> cnt_en every 4th cycle, done after 2 steps; ena low for 10 cycles mid-sweep -> no steps, resumes afterwards.
REQ-034 rst_n asserted mid-RUN -> all outputs per REQ-027 within the same cycle; lo/hi back to 0x00/0xFF.
REQ-035 lo == hi == 0x33, START up non-bounce -> one cnt_load of 0x33, zero cnt_en, done pulse.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - bounded up/down sweep controller driving an external 8-bit counter
// Optional feature: define SWEEP_COUNTER_EN to count bounce reversals on sweeps;
// left undefined, sweeps is tied to 0 and no counter register exists.
module updown_sweep_ctrl #(
   parameter int TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       abort,
   input  logic [7:0] cnt_q,
   output logic       cnt_load,
   output logic [7:0] cnt_load_val,
   output logic       cnt_en,
   output logic       cnt_up,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] sweeps
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   localparam logic [1:0] OP_SET_LO = 2'b00;
   localparam logic [1:0] OP_SET_HI = 2'b01;
   localparam logic [1:0] OP_START  = 2'b10;
   localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

   state_t     r_state;
   logic [7:0] r_lo;
   logic [7:0] r_hi;
   logic [7:0] r_target;
   logic [7:0] r_presc;
   logic       r_dir;
   logic       r_bounce;
   logic       r_err;

   logic       w_busy;
   logic       w_xfer;
   logic       w_start;
   logic       w_tick;
   logic       w_at_target;

   // Command handshake and sweep progress decode; abort in the same cycle cancels a START.
   always_comb begin
      w_busy      = (r_state == S_LOAD) || (r_state == S_RUN);
      w_xfer      = cmd_valid && !w_busy;
      w_start     = w_xfer && (cmd_op == OP_START) && !abort;
      w_tick      = (r_presc == TICK_LAST);
      w_at_target = (cnt_q == r_target);
   end

   // Main controller: command decode, load, stepping and bounce reversal; ena low freezes it all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_lo     <= 8'h00;
         r_hi     <= 8'hFF;
         r_target <= 8'h00;
         r_presc  <= 8'h00;
         r_dir    <= 1'b1;
         r_bounce <= 1'b0;
         r_err    <= 1'b0;
      end else if (ena) begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               if (w_xfer && cmd_op == OP_SET_LO) begin
                  r_lo <= cmd_data;
               end else if (w_xfer && cmd_op == OP_SET_HI) begin
                  r_hi <= cmd_data;
               end else if (w_start) begin
                  if (r_lo > r_hi) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state  <= S_LOAD;
                     r_dir    <= cmd_data[0];
                     r_bounce <= cmd_data[1];
                     r_target <= cmd_data[0] ? r_hi : r_lo;
                  end
               end
            end
            S_LOAD: begin
               r_presc <= 8'h00;
               r_state <= abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else begin
                  r_presc <= w_tick ? 8'h00 : r_presc + 8'h01;
                  if (w_at_target) begin
                     if (r_bounce) begin
                        r_dir    <= ~r_dir;
                        r_target <= r_dir ? r_lo : r_hi;
                     end else begin
                        r_state <= S_DONE;
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SWEEP_COUNTER_EN
   logic [7:0] r_sweeps;
   logic       w_reverse;
   logic       w_start_ok;

   // Reversal and valid-start strobes for the sweep counter.
   always_comb begin
      w_reverse  = ena && !abort && (r_state == S_RUN) && w_at_target && r_bounce;
      w_start_ok = ena && w_start && (r_lo <= r_hi);
   end

   // Saturating count of bounce reversals since the last accepted START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sweeps <= 8'h00;
      end else if (w_start_ok) begin
         r_sweeps <= 8'h00;
      end else if (w_reverse && r_sweeps != 8'hFF) begin
         r_sweeps <= r_sweeps + 8'h01;
      end
   end

   assign sweeps = r_sweeps;
`else
   assign sweeps = 8'h00;
`endif

   // Counter drive and status; strobes are gated by ena and abort so a frozen or aborted sweep never moves the counter.
   always_comb begin
      busy         = w_busy;
      cmd_ready    = !w_busy;
      cnt_up       = r_dir;
      cnt_load     = ena && !abort && (r_state == S_LOAD);
      cnt_load_val = cnt_load ? (r_dir ? r_lo : r_hi) : 8'h00;
      cnt_en       = ena && !abort && (r_state == S_RUN) && w_tick && !w_at_target;
      done         = ena && (r_state == S_DONE);
      err          = ena && r_err;
   end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - scoreboard bench for updown_sweep_ctrl with an external counter model
module tb_updown_sweep_ctrl;

   localparam int TDIV = 4;
   localparam logic [2:0] K_LOAD = 3'd1;
   localparam logic [2:0] K_STEP = 3'd2;
   localparam logic [2:0] K_DONE = 3'd3;
   localparam logic [2:0] K_ERR  = 3'd4;
`ifdef SWEEP_COUNTER_EN
   localparam logic [7:0] SW_ONE = 8'd1;
   localparam logic [7:0] SW_TWO = 8'd2;
`else
   localparam logic [7:0] SW_ONE = 8'd0;
   localparam logic [7:0] SW_TWO = 8'd0;
`endif

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       ena       = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op    = 2'b00;
   logic [7:0] cmd_data  = 8'h00;
   logic       abort     = 1'b0;
   logic [7:0] cnt_q     = 8'h00;
   logic       cmd_ready;
   logic       cnt_load;
   logic [7:0] cnt_load_val;
   logic       cnt_en;
   logic       cnt_up;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] sweeps;

   int          total    = 0;
   int          bad      = 0;
   int          cyc      = 0;
   int          load_cyc = 0;
   logic [11:0] sb[$];
   int          step_cyc[$];

   always #5 clk = ~clk;

   updown_sweep_ctrl #(.TICK_DIV(TDIV)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .cmd_valid    (cmd_valid),
      .cmd_op       (cmd_op),
      .cmd_data     (cmd_data),
      .cmd_ready    (cmd_ready),
      .abort        (abort),
      .cnt_q        (cnt_q),
      .cnt_load     (cnt_load),
      .cnt_load_val (cnt_load_val),
      .cnt_en       (cnt_en),
      .cnt_up       (cnt_up),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .sweeps       (sweeps)
   );

   // External up/down counter, load has priority over enable.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cnt_load)    cnt_q <= cnt_load_val;
      else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 8'h01 : cnt_q - 8'h01;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] mk(input logic [2:0] k, input logic up, input logic [7:0] v);
      return {k, up, v};
   endfunction

   task automatic sb_match(input string tag, input logic [11:0] ev);
      if (sb.size() == 0) check({tag, "_unexpected"}, ev, 12'h000);
      else                check(tag, ev, sb.pop_front());
   endtask

   // Output monitor: every counter strobe and status pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cnt_load) begin
            load_cyc = cyc;
            sb_match("load", mk(K_LOAD, 1'b0, cnt_load_val));
         end
         if (cnt_en) begin
            step_cyc.push_back(cyc);
            sb_match("step", mk(K_STEP, cnt_up, cnt_q));
         end
         if (done) sb_match("done", mk(K_DONE, 1'b0, 8'h00));
         if (err)  sb_match("err", mk(K_ERR, 1'b0, 8'h00));
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      while (!cmd_ready && n < 200) begin
         tick_n(1);
         n++;
      end
      check("cmd_ready", cmd_ready, 1);
      tick_n(1);
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 8'h00;
   endtask

   task automatic wait_sb(input int left, input int budget, input string tag);
      int n = 0;
      while (sb.size() > left && n < budget) begin
         tick_n(1);
         n++;
      end
      check(tag, sb.size(), left);
   endtask

   // Reference for a non-bounce sweep: load the start bound, one step per value, then done.
   task automatic exp_sweep(input logic [7:0] lo, input logic [7:0] hi, input logic up);
      logic [7:0] v;
      logic [7:0] tgt;
      v   = up ? lo : hi;
      tgt = up ? hi : lo;
      sb.push_back(mk(K_LOAD, 1'b0, v));
      while (v != tgt) begin
         sb.push_back(mk(K_STEP, up, v));
         v = up ? v + 8'h01 : v - 8'h01;
      end
      sb.push_back(mk(K_DONE, 1'b0, 8'h00));
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout got=%0d exp=done", cyc);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      // reset state
      tick_n(2);
      check("rst_outs", {cmd_ready, cnt_up, busy, cnt_load, cnt_en, done, err, cnt_load_val, sweeps},
            {7'b1100000, 16'h0000});
      rst_n = 1'b1;
      tick_n(1);

      // basic up sweep 0x10..0x14
      send_cmd(2'b00, 8'h10);
      send_cmd(2'b01, 8'h14);
      exp_sweep(8'h10, 8'h14, 1'b1);
      step_cyc.delete();
      send_cmd(2'b10, 8'h01);
      wait_sb(0, 200, "t30_drain");
      check("t30_steps", step_cyc.size(), 4);
      check("t30_busy", busy, 0);
      tick_n(6);
      check("t30_cntq", cnt_q, 8'h14);

      // lo > hi rejected
      send_cmd(2'b00, 8'h20);
      send_cmd(2'b01, 8'h10);
      sb.push_back(mk(K_ERR, 1'b0, 8'h00));
      send_cmd(2'b10, 8'h01);
      wait_sb(0, 20, "t31_err");
      tick_n(3);
      check("t31_busy", busy, 0);

      // lo == hi completes with no steps
      send_cmd(2'b00, 8'h33);
      send_cmd(2'b01, 8'h33);
      exp_sweep(8'h33, 8'h33, 1'b1);
      step_cyc.delete();
      send_cmd(2'b10, 8'h01);
      wait_sb(0, 50, "t35_drain");
      check("t35_steps", step_cyc.size(), 0);

      // prescaler spacing and ena freeze
      send_cmd(2'b00, 8'h00);
      send_cmd(2'b01, 8'h02);
      exp_sweep(8'h00, 8'h02, 1'b1);
      step_cyc.delete();
      send_cmd(2'b10, 8'h01);
      wait_sb(2, 100, "t33_first");
      check("t33_load_gap", step_cyc[0] - load_cyc, TDIV);
      ena = 1'b0;
      tick_n(5);
      check("t33_frozen", {cnt_en, cnt_load, done, busy}, 4'b0001);
      tick_n(5);
      ena = 1'b1;
      wait_sb(0, 100, "t33_drain");
      check("t33_steps", step_cyc.size(), 2);
      check("t33_freeze_gap", step_cyc[1] - step_cyc[0], TDIV + 10);

      // down bounce 7,6,5,6,7,6 then abort
      send_cmd(2'b00, 8'h05);
      send_cmd(2'b01, 8'h07);
      sb.push_back(mk(K_LOAD, 1'b0, 8'h07));
      sb.push_back(mk(K_STEP, 1'b0, 8'h07));
      sb.push_back(mk(K_STEP, 1'b0, 8'h06));
      sb.push_back(mk(K_STEP, 1'b1, 8'h05));
      sb.push_back(mk(K_STEP, 1'b1, 8'h06));
      sb.push_back(mk(K_STEP, 1'b0, 8'h07));
      step_cyc.delete();
      send_cmd(2'b10, 8'h02);
      wait_sb(2, 200, "t32_half");
      check("t32_sweeps1", sweeps, SW_ONE);
      wait_sb(0, 200, "t32_drain");
      check("t32_sweeps2", sweeps, SW_TWO);
      abort = 1'b1;
      @(negedge clk);
      check("t32_abort_strobes", {cnt_en, cnt_load}, 2'b00);
      tick_n(1);
      check("t32_abort_idle", busy, 0);
      tick_n(8);
      check("t32_hold", {busy, sweeps}, {1'b0, SW_TWO});
      check("t32_cntq", cnt_q, 8'h06);
      check("t32_steps", step_cyc.size(), 5);

      // START with abort high is ignored
      send_cmd(2'b10, 8'h01);
      tick_n(3);
      check("t24_ignored", {busy, sweeps}, {1'b0, SW_TWO});
      abort = 1'b0;

      // asynchronous reset mid-run
      send_cmd(2'b00, 8'h00);
      send_cmd(2'b01, 8'hFF);
      sb.push_back(mk(K_LOAD, 1'b0, 8'h00));
      sb.push_back(mk(K_STEP, 1'b1, 8'h00));
      sb.push_back(mk(K_STEP, 1'b1, 8'h01));
      send_cmd(2'b10, 8'h01);
      wait_sb(0, 100, "t34_run");
      #2;
      rst_n = 1'b0;
      #1;
      check("t34_rst_outs", {cmd_ready, cnt_up, busy, cnt_load, cnt_en, done, err, cnt_load_val, sweeps},
            {7'b1100000, 16'h0000});
      sb.delete();
      tick_n(2);
      rst_n = 1'b1;
      tick_n(1);
      sb.push_back(mk(K_LOAD, 1'b0, 8'h00));
      send_cmd(2'b10, 8'h01);
      wait_sb(0, 20, "t34_lo");
      abort = 1'b1;
      tick_n(2);
      abort = 1'b0;
      sb.push_back(mk(K_LOAD, 1'b0, 8'hFF));
      send_cmd(2'b10, 8'h00);
      wait_sb(0, 20, "t34_hi");
      abort = 1'b1;
      tick_n(2);
      abort = 1'b0;
      check("t34_idle", busy, 0);
      tick_n(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
